// File: rtl/game_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : game_pkg
//  Brief    : Shared game-state encodings, winner codes and helpers for every
//             block that decodes the global game_state bus.
//  Revision : 1.0  initial release
// ============================================================================
package game_pkg;

    // START must stay 3'b000: the start overlay drawer decodes it directly
    typedef enum logic [2:0] {
        START     = 3'b000,
        COUNTDOWN = 3'b001,
        PLAY      = 3'b010,
        PAUSE     = 3'b011,
        OVER      = 3'b100
    } game_state_t;

    localparam logic [1:0] WINNER_NONE = 2'b00;
    localparam logic [1:0] WINNER_P1   = 2'b01;
    localparam logic [1:0] WINNER_P2   = 2'b10;
    localparam logic [1:0] WINNER_DRAW = 2'b11;

    // Larger of two integers, used for sizing shared counters
    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rise_detect.sv
`default_nettype none
// ============================================================================
//  Module   : rise_detect
//  Brief    : Single-register rising-edge detector. The history register
//             resets to RST_VAL so an input held high through reset (with
//             RST_VAL = 1) does not produce a pulse after release.
//  Revision : 1.0  initial release
// ============================================================================
module rise_detect #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic pulse
);

    logic r_q;

    // One-cycle history of the input
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q <= RST_VAL;
        end else begin
            r_q <= d;
        end
    end

    assign pulse = d & ~r_q;

endmodule
`default_nettype wire

// File: rtl/game_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : game_ctrl
//  Brief    : Top-level game sequencer. Turns key and game-logic events into
//             the global game_state bus, gates gameplay with play_en and runs
//             the frame-counted countdown and game-over hold timer.
//  Revision : 1.0  initial release
// ============================================================================
module game_ctrl
    import game_pkg::*;
#(
    parameter int FRAMES_PER_SEC = 60,
    parameter int COUNT_SECS     = 3,
    parameter int OVER_SECS      = 5
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              enter,
    input  logic                              esc,
    input  logic                              vblnk,
    input  logic                              p1_dead,
    input  logic                              p2_dead,
    output logic [2:0]                        game_state,
    output logic                              play_en,
    output logic [$clog2(COUNT_SECS+1)-1:0]   countdown,
    output logic [1:0]                        winner,
    output logic                              state_chg
);

    // A single-frame second still needs a 1-bit frame counter
    localparam int FRAME_W = (FRAMES_PER_SEC > 1) ? $clog2(FRAMES_PER_SEC) : 1;
    localparam int SEC_W   = $clog2(max_int(COUNT_SECS, OVER_SECS) + 1);
    localparam int CD_W    = $clog2(COUNT_SECS + 1);

    localparam logic [FRAME_W-1:0] C_FRAME_LAST = FRAME_W'(FRAMES_PER_SEC - 1);
    localparam logic [SEC_W-1:0]   C_COUNT_LOAD = SEC_W'(COUNT_SECS);
    localparam logic [SEC_W-1:0]   C_OVER_LOAD  = SEC_W'(OVER_SECS);
    localparam logic [SEC_W-1:0]   C_SEC_ONE    = SEC_W'(1);

    logic w_enter_p;
    logic w_esc_p;
    logic w_tick;

    game_state_t        r_state;
    game_state_t        w_next;
    logic               r_state_chg;
    logic               r_play_en;
    logic [1:0]         r_winner;
    logic [1:0]         w_dead_winner;

    logic [FRAME_W-1:0] r_frame_cnt;
    logic [SEC_W-1:0]   r_sec_cnt;
    logic               w_roll;
    logic               w_expire;

    rise_detect #(.RST_VAL(1'b1)) u_enter_edge (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (enter),
        .pulse (w_enter_p)
    );

    rise_detect #(.RST_VAL(1'b1)) u_esc_edge (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (esc),
        .pulse (w_esc_p)
    );

    rise_detect #(.RST_VAL(1'b1)) u_vblnk_edge (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (vblnk),
        .pulse (w_tick)
    );

    // A second rolls over on the tick that completes its last frame;
    // the timer expires when that rollover finishes the final second
    assign w_roll   = w_tick & (r_frame_cnt == C_FRAME_LAST);
    assign w_expire = w_roll & (r_sec_cnt <= C_SEC_ONE);

    // Winner code is the player left standing; both dead is a draw
    assign w_dead_winner = (p1_dead & p2_dead) ? WINNER_DRAW :
                           p1_dead             ? WINNER_P2   : WINNER_P1;

    // Next-state selection; death outranks Esc in PLAY, Esc outranks Enter in PAUSE
    always_comb begin
        w_next = r_state;
        case (r_state)
            START:     if (w_enter_p) w_next = COUNTDOWN;
            COUNTDOWN: if (w_expire)  w_next = PLAY;
            PLAY: begin
                if (p1_dead | p2_dead) w_next = OVER;
                else if (w_esc_p)      w_next = PAUSE;
            end
            PAUSE: begin
                if (w_esc_p)        w_next = PLAY;
                else if (w_enter_p) w_next = START;
            end
            OVER:      if (w_enter_p | w_expire) w_next = START;
            default:   w_next = START;
        endcase
    end

    // State register with registered change pulse, play gate and winner latch
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= START;
            r_state_chg <= 1'b0;
            r_play_en   <= 1'b0;
            r_winner    <= WINNER_NONE;
        end else begin
            r_state     <= w_next;
            r_state_chg <= (w_next != r_state);
            r_play_en   <= (w_next == PLAY);
            if ((r_state == PLAY) && (w_next == OVER)) begin
                r_winner <= w_dead_winner;
            end else if (w_next == START) begin
                r_winner <= WINNER_NONE;
            end
        end
    end

    // Shared seconds/frames timer: loaded on entry to COUNTDOWN or OVER,
    // counts ticks while there, and parks at zero everywhere else
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_frame_cnt <= '0;
            r_sec_cnt   <= '0;
        end else if (w_next != r_state) begin
            r_frame_cnt <= '0;
            case (w_next)
                COUNTDOWN: r_sec_cnt <= C_COUNT_LOAD;
                OVER:      r_sec_cnt <= C_OVER_LOAD;
                default:   r_sec_cnt <= '0;
            endcase
        end else if ((r_state == COUNTDOWN) || (r_state == OVER)) begin
            if (w_roll) begin
                r_frame_cnt <= '0;
                if (r_sec_cnt != '0) begin
                    r_sec_cnt <= r_sec_cnt - 1'b1;
                end
            end else if (w_tick) begin
                r_frame_cnt <= r_frame_cnt + 1'b1;
            end
        end else begin
            r_frame_cnt <= '0;
            r_sec_cnt   <= '0;
        end
    end

    assign game_state = r_state;
    assign play_en    = r_play_en;
    assign winner     = r_winner;
    assign state_chg  = r_state_chg;
    assign countdown  = (r_state == COUNTDOWN) ? r_sec_cnt[CD_W-1:0] : '0;

endmodule
`default_nettype wire

// File: tb/tb_game_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_game_ctrl
//  Brief    : Self-checking bench for game_ctrl. A tick-counting behavioural
//             model predicts every output each cycle; directed scenarios add
//             literal expectations, then randomized traffic runs.
//  Revision : 1.0  initial release
// ============================================================================
module tb_game_ctrl;

    localparam int FPS   = 60;
    localparam int CSECS = 3;
    localparam int OSECS = 5;

    localparam int M_START = 0;
    localparam int M_CD    = 1;
    localparam int M_PLAY  = 2;
    localparam int M_PAUSE = 3;
    localparam int M_OVER  = 4;

    logic       clk     = 1'b0;
    logic       rst_n   = 1'b0;
    logic       enter   = 1'b0;
    logic       esc     = 1'b0;
    logic       vblnk   = 1'b0;
    logic       p1_dead = 1'b0;
    logic       p2_dead = 1'b0;
    logic [2:0] game_state;
    logic       play_en;
    logic [1:0] countdown;
    logic [1:0] winner;
    logic       state_chg;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: mode, ticks remaining in the running timer, winner code, change flag
    int m_state = M_START;
    int m_left  = 0;
    int m_win   = 0;
    bit m_chg   = 1'b0;
    bit pe      = 1'b1;
    bit ps      = 1'b1;
    bit pv      = 1'b1;

    game_ctrl #(
        .FRAMES_PER_SEC (FPS),
        .COUNT_SECS     (CSECS),
        .OVER_SECS      (OSECS)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enter      (enter),
        .esc        (esc),
        .vblnk      (vblnk),
        .p1_dead    (p1_dead),
        .p2_dead    (p2_dead),
        .game_state (game_state),
        .play_en    (play_en),
        .countdown  (countdown),
        .winner     (winner),
        .state_chg  (state_chg)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Advance the model by one clock edge using the inputs sampled at that edge
    task automatic model_step();
        bit ep, sp, tp;
        int nxt;
        if (!rst_n) begin
            m_state = M_START; m_left = 0; m_win = 0; m_chg = 1'b0;
            pe = 1'b1; ps = 1'b1; pv = 1'b1;
            return;
        end
        ep = enter && !pe;
        sp = esc   && !ps;
        tp = vblnk && !pv;
        pe = enter; ps = esc; pv = vblnk;
        nxt = m_state;
        case (m_state)
            M_START: if (ep) begin nxt = M_CD; m_left = CSECS * FPS; end
            M_CD: if (tp) begin
                m_left--;
                if (m_left == 0) nxt = M_PLAY;
            end
            M_PLAY: begin
                if (p1_dead || p2_dead) begin
                    nxt = M_OVER;
                    m_left = OSECS * FPS;
                    if (p1_dead && p2_dead) m_win = 3;
                    else if (p1_dead)       m_win = 2;
                    else                    m_win = 1;
                end else if (sp) begin
                    nxt = M_PAUSE;
                end
            end
            M_PAUSE: begin
                if (sp)      nxt = M_PLAY;
                else if (ep) nxt = M_START;
            end
            M_OVER: begin
                if (ep) nxt = M_START;
                else if (tp) begin
                    m_left--;
                    if (m_left == 0) nxt = M_START;
                end
            end
            default: nxt = M_START;
        endcase
        if (nxt == M_START) m_win = 0;
        m_chg   = (nxt != m_state);
        m_state = nxt;
    endtask

    // Every-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        if (!rst_n) begin
            check("rst_state",     game_state, 0);
            check("rst_play_en",   play_en,    0);
            check("rst_countdown", countdown,  0);
            check("rst_winner",    winner,     0);
            check("rst_state_chg", state_chg,  0);
        end else begin
            check("state",     game_state, m_state);
            check("play_en",   play_en,    (m_state == M_PLAY) ? 1 : 0);
            check("countdown", countdown,  (m_state == M_CD) ? (m_left + FPS - 1) / FPS : 0);
            check("winner",    winner,     m_win);
            check("state_chg", state_chg,  m_chg);
        end
    end

    task automatic cyc();
        @(posedge clk);
        model_step();
        #2;
    endtask

    task automatic tick();
        vblnk = 1'b1; cyc();
        vblnk = 1'b0; cyc();
    endtask

    task automatic press_enter();
        enter = 1'b1; cyc();
        enter = 1'b0; cyc();
    endtask

    task automatic go_play();
        press_enter();
        repeat (CSECS * FPS) tick();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, game_state %0d, required finish", game_state);
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset with Enter held: no pulse after release
        enter = 1'b1;
        repeat (3) cyc();
        rst_n = 1'b1;
        repeat (3) cyc();
        check("held_enter_start", game_state, 3'b000);
        enter = 1'b0; cyc();
        enter = 1'b1; cyc();
        check("enter_to_cd",   game_state, 3'b001);
        check("cd_initial",    countdown,  3);
        check("enter_chg",     state_chg,  1);
        enter = 1'b0; cyc();
        check("chg_one_cycle", state_chg,  0);

        // Countdown: 179 ticks still counting, 180th enters PLAY
        repeat (CSECS * FPS - 1) tick();
        check("cd_179_state", game_state, 3'b001);
        check("cd_179_value", countdown,  1);
        vblnk = 1'b1; cyc();
        check("cd_180_state", game_state, 3'b010);
        check("cd_180_play",  play_en,    1);
        vblnk = 1'b0; cyc();

        // Death beats Esc in the same cycle
        esc = 1'b1; p2_dead = 1'b1; cyc();
        check("p2_dead_over",   game_state, 3'b100);
        check("p2_dead_winner", winner,     2'b01);
        esc = 1'b0; p2_dead = 1'b0; cyc();
        press_enter();
        check("over_enter_start", game_state, 3'b000);
        go_play();
        p1_dead = 1'b1; p2_dead = 1'b1; cyc();
        check("draw_winner", winner, 2'b11);
        p1_dead = 1'b0; p2_dead = 1'b0; cyc();
        press_enter();

        // Pause / resume / abort
        go_play();
        esc = 1'b1; cyc();
        check("pause_state",   game_state, 3'b011);
        check("pause_play_en", play_en,    0);
        esc = 1'b0; cyc();
        esc = 1'b1; enter = 1'b1; cyc();
        check("esc_wins_resume", game_state, 3'b010);
        esc = 1'b0; enter = 1'b0; cyc();
        esc = 1'b1; cyc();
        check("pause_again", game_state, 3'b011);
        esc = 1'b0; cyc();
        enter = 1'b1; cyc();
        check("abort_to_start", game_state, 3'b000);
        enter = 1'b0; cyc();

        // OVER expiry after 300 ticks
        go_play();
        p1_dead = 1'b1; cyc();
        check("p1_dead_winner", winner, 2'b10);
        p1_dead = 1'b0; cyc();
        repeat (OSECS * FPS - 1) tick();
        check("over_299_state", game_state, 3'b100);
        vblnk = 1'b1; cyc();
        check("over_300_state",  game_state, 3'b000);
        check("over_300_winner", winner,     2'b00);
        vblnk = 1'b0; cyc();

        // OVER early exit with Enter
        go_play();
        p2_dead = 1'b1; cyc();
        p2_dead = 1'b0; cyc();
        repeat (10) tick();
        enter = 1'b1; cyc();
        check("over_enter_exit", game_state, 3'b000);
        enter = 1'b0; cyc();

        // Reset in the middle of the countdown
        press_enter();
        repeat (90) tick();
        rst_n = 1'b0; cyc();
        check("mid_rst_state",     game_state, 3'b000);
        check("mid_rst_countdown", countdown,  0);
        repeat (2) cyc();
        rst_n = 1'b1; cyc();
        repeat (10) tick();
        check("ticks_stay_start", game_state, 3'b000);

        // Randomized traffic
        for (int i = 0; i < 25000; i++) begin
            enter   = ($urandom_range(0, 9) == 0);
            esc     = ($urandom_range(0, 15) == 0);
            vblnk   = $urandom_range(0, 1);
            p1_dead = ($urandom_range(0, 79) == 0);
            p2_dead = ($urandom_range(0, 79) == 0);
            rst_n   = ($urandom_range(0, 4999) != 0);
            cyc();
        end
        rst_n = 1'b1; enter = 1'b0; esc = 1'b0; vblnk = 1'b0;
        p1_dead = 1'b0; p2_dead = 1'b0;
        repeat (2) cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
